// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding common to uart_tx/uart_rx and oversampling constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, reset to a chosen idle level.
// Latency: 2 clk.
// Backpressure: none, free-running.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: start-bit glitch rejection, mid-bit sampling, LSB-first, stop check.
// Latency: rx_done_tick one clk after the final stop s_tick (plus 2 clk synchroniser on rx).
// Backpressure: none; downstream FIFO must accept every rx_done_tick.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err
);

    localparam int SW = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_MID      = SW'(MID_SAMPLE);
    localparam logic [SW-1:0] S_BIT_END  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

    logic rx_s;

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    uart_state_t     state_reg, state_next;
    logic [SW-1:0]   s_reg, s_next;
    logic [NW-1:0]   n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic            done_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            s_reg        <= '0;
            n_reg        <= '0;
            b_reg        <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            s_reg        <= s_next;
            n_reg        <= n_next;
            b_reg        <= b_next;
            rx_done_tick <= done_next;
            if (done_next) begin
                dout      <= b_reg;
                frame_err <= ~rx_s;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_reg == S_MID) begin
                        // Line back high by mid-start means a glitch, not a start bit.
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s_reg + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == S_BIT_END) begin
                        s_next = '0;
                        b_next = {rx_s, b_reg[DBIT-1:1]};
                        if (n_reg == N_LAST) begin
                            state_next = STOP;
                        end else begin
                            n_next = n_reg + NW'(1);
                        end
                    end else begin
                        s_next = s_reg + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    // Stop is judged at its last tick so idle can catch the next start at once.
                    if (s_reg == S_STOP_END) begin
                        state_next = IDLE;
                        s_next     = '0;
                        done_next  = 1'b1;
                    end else begin
                        s_next = s_reg + SW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: s_tick every 4 clk, rx driven per 64-clk bit, expected words queued per frame.
module tb_uart_rx;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       rx2;
    logic       s_tick;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       frame_err;
    logic       rx_done_tick2;
    logic [7:0] dout2;
    logic       frame_err2;

    int n_chk;
    int n_err;
    int cyc;
    int done_cnt;
    int fall_cyc;
    int last_lat;
    int lat16;
    int lat32;

    logic [8:0] exp_q[$];
    logic [8:0] exp_q2[$];

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .frame_err    (frame_err)
    );

    uart_rx #(.DBIT(8), .SB_TICK(32)) dut32 (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx2),
        .s_tick       (s_tick),
        .rx_done_tick (rx_done_tick2),
        .dout         (dout2),
        .frame_err    (frame_err2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (rx_done_tick === 1'b1) done_cnt <= done_cnt + 1;

    initial begin
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            s_tick = (cyc % 4 == 0);
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 60000 clk, failures so far %0d", n_err);
        $fatal(1, "watchdog");
    end

    // Sends one frame aligned to the tick phase; stop_low holds the stop bit low for 48 clk.
    task automatic send_frame(input logic [7:0] d, input logic stop_low, input logic line2, input logic push);
        while (cyc % 4 != 0) @(negedge clk);
        if (push) begin
            if (line2) exp_q2.push_back({stop_low, d});
            else       exp_q.push_back({stop_low, d});
        end
        fall_cyc = cyc;
        if (line2) rx2 = 1'b0; else rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (line2) rx2 = d[i]; else rx = d[i];
            repeat (64) @(negedge clk);
        end
        if (stop_low) begin
            if (line2) rx2 = 1'b0; else rx = 1'b0;
            repeat (48) @(negedge clk);
            if (line2) rx2 = 1'b1; else rx = 1'b1;
            repeat (16) @(negedge clk);
        end else begin
            if (line2) rx2 = 1'b1; else rx = 1'b1;
            repeat (64) @(negedge clk);
        end
    endtask

    task automatic expect_frames(input int n);
        logic [8:0] e;
        int t;
        for (int k = 0; k < n; k++) begin
            t = 0;
            @(negedge clk);
            while (rx_done_tick !== 1'b1 && t < 1500) begin
                @(negedge clk);
                t++;
            end
            n_chk++;
            if (rx_done_tick !== 1'b1) begin
                n_err++;
                $display("FAIL done_timeout frame %0d: no rx_done_tick within %0d clk", k, t);
            end else if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: pulse with dout=%h but nothing expected", dout);
            end else begin
                last_lat = cyc - fall_cyc;
                e = exp_q.pop_front();
                if (dout !== e[7:0]) begin
                    n_err++;
                    $display("FAIL dout: got %h expected %h", dout, e[7:0]);
                end
                n_chk++;
                if (frame_err !== e[8]) begin
                    n_err++;
                    $display("FAIL frame_err: got %b expected %b (dout %h)", frame_err, e[8], e[7:0]);
                end
                @(negedge clk);
                n_chk++;
                if (rx_done_tick !== 1'b0) begin
                    n_err++;
                    $display("FAIL done_width: rx_done_tick still %b one clk after pulse", rx_done_tick);
                end
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx    = 1'b1;
        rx2   = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (rx_done_tick !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", rx_done_tick); end
        n_chk++;
        if (dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h expected 00", dout); end
        n_chk++;
        if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        n_chk++;
        if (rx_done_tick !== 1'b0 || dout !== 8'h00 || frame_err !== 1'b0 || done_cnt != 0) begin
            n_err++;
            $display("FAIL idle_after_reset: done=%b dout=%h ferr=%b pulses=%0d expected 0/00/0/0",
                     rx_done_tick, dout, frame_err, done_cnt);
        end
    endtask

    task automatic test_basic;
        int snap;
        snap = done_cnt;
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
            expect_frames(1);
        join
        lat16 = last_lat;
        n_chk++;
        if (lat16 < 605 || lat16 > 615) begin
            n_err++;
            $display("FAIL latency16: got %0d clk expected 610 +/-5", lat16);
        end
        repeat (10) @(negedge clk);
        n_chk++;
        if (done_cnt - snap != 1) begin
            n_err++;
            $display("FAIL pulse_count_basic: got %0d expected 1", done_cnt - snap);
        end
    endtask

    task automatic test_back_to_back;
        fork
            begin
                send_frame(8'h00, 1'b0, 1'b0, 1'b1);
                send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
            end
            expect_frames(2);
        join
        repeat (10) @(negedge clk);
    endtask

    task automatic test_glitch;
        int snap;
        snap = done_cnt;
        while (cyc % 4 != 0) @(negedge clk);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        n_chk++;
        if (done_cnt != snap) begin
            n_err++;
            $display("FAIL glitch_pulse: got %0d pulses expected 0", done_cnt - snap);
        end
        fork
            send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
            expect_frames(1);
        join
        repeat (10) @(negedge clk);
    endtask

    task automatic test_frame_err;
        fork
            begin
                send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
                send_frame(8'h81, 1'b0, 1'b0, 1'b1);
            end
            expect_frames(2);
        join
        repeat (10) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d frames outstanding expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        int snap;
        snap = done_cnt;
        while (cyc % 4 != 0) @(negedge clk);
        fork
            send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
            begin
                repeat (340) @(negedge clk);
                reset = 1'b1;
                repeat (5) @(negedge clk);
                reset = 1'b0;
            end
        join
        repeat (150) @(negedge clk);
        n_chk++;
        if (done_cnt != snap) begin
            n_err++;
            $display("FAIL reset_mid_pulse: got %0d pulses expected 0", done_cnt - snap);
        end
        n_chk++;
        if (dout !== 8'h00) begin n_err++; $display("FAIL reset_mid_dout: got %h expected 00", dout); end
        fork
            send_frame(8'h69, 1'b0, 1'b0, 1'b1);
            expect_frames(1);
        join
        repeat (10) @(negedge clk);
    endtask

    task automatic test_sb32;
        logic [8:0] e;
        int t;
        fork
            send_frame(8'h96, 1'b0, 1'b1, 1'b1);
            begin
                t = 0;
                @(negedge clk);
                while (rx_done_tick2 !== 1'b1 && t < 1500) begin
                    @(negedge clk);
                    t++;
                end
                n_chk++;
                if (rx_done_tick2 !== 1'b1 || exp_q2.size() == 0) begin
                    n_err++;
                    $display("FAIL sb32_done: pulse=%b queued=%0d expected pulse with 1 queued",
                             rx_done_tick2, exp_q2.size());
                end else begin
                    lat32 = cyc - fall_cyc;
                    e = exp_q2.pop_front();
                    if (dout2 !== e[7:0] || frame_err2 !== e[8]) begin
                        n_err++;
                        $display("FAIL sb32_data: got dout %h ferr %b expected %h %b",
                                 dout2, frame_err2, e[7:0], e[8]);
                    end
                end
            end
        join
        n_chk++;
        if (lat32 - lat16 != 64) begin
            n_err++;
            $display("FAIL sb32_delay: got %0d clk later expected 64", lat32 - lat16);
        end
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        cyc      = 0;
        done_cnt = 0;
        fall_cyc = 0;
        last_lat = 0;
        lat16    = 0;
        lat32    = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_sb32();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
